// File: rtl/uart_tx_sched_pkg.sv
// Shared definitions for the transmitter scheduler: FSM state encodings and byte width.
package uart_tx_sched_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_SEND  = 3'd2,
    ST_GUARD = 3'd3,
    ST_WAIT  = 3'd4
  } state_t;

endpackage

// File: rtl/uart_tx_sched_rr_pick.sv
// Combinational round-robin priority picker: first set request at or above ptr, with wrap.
module rr_pick #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] idx,
  output logic         any
);

  int slot;

  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    slot = 0;
    for (int i = 0; i < N; i++) begin
      slot = int'(ptr) + i;
      if (slot >= N) slot = slot - N;
      if (!any && req[slot]) begin
        gnt[slot] = 1'b1;
        idx       = W'(slot);
        any       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one byte transmitter among NUM_REQ requesters,
// with an optional lock that keeps the line for one requester until its last byte.
//
// state | meaning
// IDLE  | arbitrate (only the owner while locked); run the lock timeout
// FETCH | Ready pulse to the grantee, latch its byte and last flag
// SEND  | TxEn pulse
// GUARD | one cycle so the stale done level is not sampled
// WAIT  | hold until done; advance pointer; set or clear the lock
module uart_tx_sched
  import uart_tx_sched_pkg::*;
#(
  parameter  int NUM_REQ      = 4,
  parameter  int LOCK_TIMEOUT = 1024,
  localparam int GRANT_W      = $clog2(NUM_REQ)
) (
  input  logic                      i_Clk,
  input  logic                      i_Rst,
  input  logic [NUM_REQ-1:0]        i_Req_Valid,
  input  logic [BYTE_W*NUM_REQ-1:0] i_Req_Data,
  input  logic [NUM_REQ-1:0]        i_Req_Last,
  output logic [NUM_REQ-1:0]        o_Req_Ready,
  output logic                      o_TxEn,
  output logic [BYTE_W-1:0]         o_TxData,
  input  logic                      i_TxDone,
  output logic [NUM_REQ-1:0]        o_Grant,
  output logic                      o_Busy
);

  localparam int CNT_W = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_TC = CNT_W'((LOCK_TIMEOUT > 0) ? LOCK_TIMEOUT - 1 : 0);

  state_t              state_q, state_d;
  logic [GRANT_W-1:0]  g_idx_q, g_idx_d;
  logic [GRANT_W-1:0]  ptr_q, ptr_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [NUM_REQ-1:0]  ready_q, ready_d;
  logic                txen_q, txen_d;
  logic [BYTE_W-1:0]   data_q, data_d;
  logic                last_q, last_d;
  logic                lock_q, lock_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                busy_q;

  logic [NUM_REQ-1:0]  elig;
  logic [NUM_REQ-1:0]  pick_gnt;
  logic [GRANT_W-1:0]  pick_idx;
  logic                pick_any;

  // While locked the held grant vector doubles as the owner mask.
  assign elig = lock_q ? (i_Req_Valid & grant_q) : i_Req_Valid;

  rr_pick #(.N(NUM_REQ), .W(GRANT_W)) u_pick (
    .req (elig),
    .ptr (ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  always_comb begin
    state_d = state_q;
    g_idx_d = g_idx_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    ready_d = '0;
    txen_d  = 1'b0;
    data_d  = data_q;
    last_d  = last_q;
    lock_d  = lock_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        // Timeout is checked first so a late owner re-competes instead of keeping the line.
        if (lock_q && cnt_q == CNT_TC) begin
          lock_d  = 1'b0;
          grant_d = '0;
          cnt_d   = '0;
        end else if (pick_any) begin
          g_idx_d = pick_idx;
          grant_d = pick_gnt;
          ready_d = pick_gnt;
          cnt_d   = '0;
          state_d = ST_FETCH;
        end else if (lock_q) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_FETCH: begin
        if (i_Req_Valid[g_idx_q]) begin
          data_d  = i_Req_Data[BYTE_W*g_idx_q +: BYTE_W];
          last_d  = i_Req_Last[g_idx_q];
          txen_d  = 1'b1;
          state_d = ST_SEND;
        end else begin
          if (!lock_q) grant_d = '0;
          state_d = ST_IDLE;
        end
      end
      ST_SEND:  state_d = ST_GUARD;
      ST_GUARD: state_d = ST_WAIT;
      ST_WAIT: begin
        if (i_TxDone) begin
          ptr_d = (g_idx_q == GRANT_W'(NUM_REQ - 1)) ? '0 : g_idx_q + 1'b1;
          if (LOCK_TIMEOUT != 0 && !last_q) begin
            lock_d = 1'b1;
          end else begin
            lock_d  = 1'b0;
            grant_d = '0;
          end
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state_q <= ST_IDLE;
      g_idx_q <= '0;
      ptr_q   <= '0;
      grant_q <= '0;
      ready_q <= '0;
      txen_q  <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
      lock_q  <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      g_idx_q <= g_idx_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      ready_q <= ready_d;
      txen_q  <= txen_d;
      data_q  <= data_d;
      last_q  <= last_d;
      lock_q  <= lock_d;
      cnt_q   <= cnt_d;
      busy_q  <= (state_d != ST_IDLE) | lock_d;
    end
  end

  assign o_Req_Ready = ready_q;
  assign o_TxEn      = txen_q;
  assign o_TxData    = data_q;
  assign o_Grant     = grant_q;
  assign o_Busy      = busy_q;

endmodule
